// File: rtl/memory_arbiter_pkg.sv
// Shared widths, memory codes and owner encoding
// for the two-port memory arbiter slice.
package memory_arbiter_pkg;

  localparam int ADDR_W      = 32;
  localparam int WORD_W      = 32;
  localparam int MEM_COUNT_W = 2;
  localparam int MEM_CODE_W  = 3;
  localparam int WORD_COUNT  = 64;

  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = 2'd0;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 2'd1;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 2'd2;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 2'd3;

  localparam logic [MEM_CODE_W-1:0] MEM_CODE_INVALID       = 3'd0;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_READ          = 3'd1;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_WRITE         = 3'd2;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_MISALIGNED    = 3'd3;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_OUT_OF_BOUNDS = 3'd4;

  localparam int DEF_STARVE_LIMIT = 4;
  localparam int DEF_STARVE_W     = 3;

  // Move to a shared header if a third requester appears.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_F    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  function automatic logic is_err_code(
    input logic [MEM_CODE_W-1:0] c
  );
    return (c == MEM_CODE_MISALIGNED) ||
           (c == MEM_CODE_OUT_OF_BOUNDS);
  endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Core-side F/D ports and memory request bus.
// slave = arbiter view, master = environment view.
interface memory_arbiter_if;
  import memory_arbiter_pkg::*;

  logic                   i_f_req;
  logic [ADDR_W-1:0]      i_f_addr;
  logic [MEM_COUNT_W-1:0] i_f_count;
  logic                   o_f_gnt;
  logic                   o_f_rsp_valid;
  logic [WORD_W-1:0]      o_f_rd_data;
  logic [MEM_CODE_W-1:0]  o_f_code;

  logic                   i_d_req;
  logic [ADDR_W-1:0]      i_d_addr;
  logic [WORD_W-1:0]      i_d_wr_data;
  logic                   i_d_wr_en;
  logic [MEM_COUNT_W-1:0] i_d_count;
  logic                   o_d_gnt;
  logic                   o_d_rsp_valid;
  logic [WORD_W-1:0]      o_d_rd_data;
  logic [MEM_CODE_W-1:0]  o_d_code;

  logic [ADDR_W-1:0]      o_mem_addr;
  logic [WORD_W-1:0]      o_mem_wr_data;
  logic                   o_mem_wr_en;
  logic [MEM_COUNT_W-1:0] o_mem_count;
  logic [WORD_W-1:0]      i_mem_rd_data;
  logic [MEM_CODE_W-1:0]  i_mem_code;

  modport slave (
    input  i_f_req, i_f_addr, i_f_count,
    output o_f_gnt, o_f_rsp_valid,
    output o_f_rd_data, o_f_code,
    input  i_d_req, i_d_addr, i_d_wr_data,
    input  i_d_wr_en, i_d_count,
    output o_d_gnt, o_d_rsp_valid,
    output o_d_rd_data, o_d_code,
    output o_mem_addr, o_mem_wr_data,
    output o_mem_wr_en, o_mem_count,
    input  i_mem_rd_data, i_mem_code
  );

  modport master (
    output i_f_req, i_f_addr, i_f_count,
    input  o_f_gnt, o_f_rsp_valid,
    input  o_f_rd_data, o_f_code,
    output i_d_req, i_d_addr, i_d_wr_data,
    output i_d_wr_en, i_d_count,
    input  o_d_gnt, o_d_rsp_valid,
    input  o_d_rd_data, o_d_code,
    input  o_mem_addr, o_mem_wr_data,
    input  o_mem_wr_en, o_mem_count,
    output i_mem_rd_data, i_mem_code
  );

endinterface

// File: rtl/memory_arbiter.sv
// Shares one memory between fetch (F) and load/store (D).
// D has priority; F wins once starved STARVE_LIMIT cycles.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int STARVE_W     = DEF_STARVE_W
) (
  input  logic                  clk,
  input  logic                  aresetn,
  memory_arbiter_if.slave       bus,
  output logic [1:0]            o_err_sticky,
  input  logic                  i_err_clr
);

  localparam logic [STARVE_W-1:0] LIM =
    STARVE_W'(STARVE_LIMIT);

  logic                f_win;
  logic                d_win;
  logic [STARVE_W-1:0] starve_q, starve_d;
  owner_e              owner_q, owner_d;
  logic [1:0]          err_q, err_d;
  logic                f_own;
  logic                d_own;

  // Pick the winner; F only beats D when starved.
  always_comb begin
    f_win = bus.i_f_req &&
            (!bus.i_d_req || starve_q == LIM);
    d_win = bus.i_d_req && !f_win;
  end

  assign bus.o_f_gnt = f_win;
  assign bus.o_d_gnt = d_win;

  // Drive the memory bus from the winner or idle.
  always_comb begin
    bus.o_mem_addr    = '0;
    bus.o_mem_wr_data = '0;
    bus.o_mem_wr_en   = 1'b0;
    bus.o_mem_count   = MEM_COUNT_NONE;
    unique case (1'b1)
      f_win: begin
        bus.o_mem_addr  = bus.i_f_addr;
        bus.o_mem_count = bus.i_f_count;
      end
      d_win: begin
        bus.o_mem_addr    = bus.i_d_addr;
        bus.o_mem_wr_data = bus.i_d_wr_data;
        bus.o_mem_wr_en   = bus.i_d_wr_en;
        bus.o_mem_count   = bus.i_d_count;
      end
      default: ;
    endcase
  end

  // Next owner, starvation count and sticky errors.
  always_comb begin
    owner_d = OWN_NONE;
    if (f_win)      owner_d = OWN_F;
    else if (d_win) owner_d = OWN_D;

    starve_d = starve_q;
    if (!bus.i_f_req || f_win)
      starve_d = '0;
    else if (starve_q != LIM)
      starve_d = starve_q + 1'b1;

    err_d = err_q;
    if (i_err_clr) err_d = 2'b00;
    if (is_err_code(bus.i_mem_code)) begin
      if (owner_q == OWN_F) err_d[0] = 1'b1;
      if (owner_q == OWN_D) err_d[1] = 1'b1;
    end
  end

  // State registers; reset drops any in-flight reply.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      owner_q  <= OWN_NONE;
      starve_q <= '0;
      err_q    <= 2'b00;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  assign f_own        = (owner_q == OWN_F);
  assign d_own        = (owner_q == OWN_D);
  assign o_err_sticky = err_q;

  // Steer the registered memory reply to its owner.
  always_comb begin
    bus.o_f_rsp_valid = f_own;
    bus.o_f_rd_data   = f_own ? bus.i_mem_rd_data : '0;
    bus.o_f_code      = f_own ? bus.i_mem_code
                              : MEM_CODE_INVALID;
    bus.o_d_rsp_valid = d_own;
    bus.o_d_rd_data   = d_own ? bus.i_mem_rd_data : '0;
    bus.o_d_code      = d_own ? bus.i_mem_code
                              : MEM_CODE_INVALID;
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a
// small registered memory model.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  logic       clk;
  logic       aresetn;
  logic       err_clr;
  logic [1:0] err_sticky;
  int         n_cmp;
  int         n_bad;

  memory_arbiter_if bus();

  memory_arbiter dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .bus          (bus.slave),
    .o_err_sticky (err_sticky),
    .i_err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [WORD_W-1:0]     mem [WORD_COUNT];
  logic [WORD_W-1:0]     m_data_q;
  logic [MEM_CODE_W-1:0] m_code_q;

  assign bus.i_mem_rd_data = m_data_q;
  assign bus.i_mem_code    = m_code_q;

  always @(posedge clk) begin
    m_data_q <= '0;
    if (bus.o_mem_count == MEM_COUNT_NONE)
      m_code_q <= MEM_CODE_INVALID;
    else if (bus.o_mem_addr >= 32'(4 * WORD_COUNT))
      m_code_q <= MEM_CODE_OUT_OF_BOUNDS;
    else if ((bus.o_mem_count == MEM_COUNT_HALF &&
              bus.o_mem_addr[0]) ||
             (bus.o_mem_count == MEM_COUNT_WORD &&
              bus.o_mem_addr[1:0] != 2'b00))
      m_code_q <= MEM_CODE_MISALIGNED;
    else if (bus.o_mem_wr_en) begin
      mem[bus.o_mem_addr[7:2]] <= bus.o_mem_wr_data;
      m_code_q <= MEM_CODE_WRITE;
    end else begin
      m_data_q <= mem[bus.o_mem_addr[7:2]];
      m_code_q <= MEM_CODE_READ;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.i_f_req     = 1'b0;
    bus.i_f_addr    = '0;
    bus.i_f_count   = MEM_COUNT_NONE;
    bus.i_d_req     = 1'b0;
    bus.i_d_addr    = '0;
    bus.i_d_wr_data = '0;
    bus.i_d_wr_en   = 1'b0;
    bus.i_d_count   = MEM_COUNT_NONE;
  endtask

  task automatic d_req(input logic [31:0] a,
                       input logic [31:0] wd,
                       input logic we,
                       input logic [1:0] cnt);
    bus.i_d_req     = 1'b1;
    bus.i_d_addr    = a;
    bus.i_d_wr_data = wd;
    bus.i_d_wr_en   = we;
    bus.i_d_count   = cnt;
  endtask

  task automatic f_req(input logic [31:0] a,
                       input logic [1:0] cnt);
    bus.i_f_req   = 1'b1;
    bus.i_f_addr  = a;
    bus.i_f_count = cnt;
  endtask

  initial begin
    logic exp_f;
    n_cmp   = 0;
    n_bad   = 0;
    err_clr = 1'b0;
    aresetn = 1'b0;
    idle_in();
    tick();
    tick();

    chk("rst_count", 64'(bus.o_mem_count),
        64'(MEM_COUNT_NONE));
    chk("rst_wr_en", 64'(bus.o_mem_wr_en), 0);
    chk("rst_gnt", 64'({bus.o_f_gnt, bus.o_d_gnt}), 0);
    chk("rst_rsp", 64'({bus.o_f_rsp_valid,
                        bus.o_d_rsp_valid}), 0);
    chk("rst_err", 64'(err_sticky), 0);
    chk("rst_fdata", 64'(bus.o_f_rd_data), 0);

    aresetn = 1'b1;
    tick();

    d_req(32'h10, 32'hDEADBEEF, 1'b1, MEM_COUNT_WORD);
    #1;
    chk("dw_gnt", 64'({bus.o_f_gnt, bus.o_d_gnt}), 2'b01);
    chk("dw_addr", 64'(bus.o_mem_addr), 32'h10);
    chk("dw_we", 64'(bus.o_mem_wr_en), 1);
    tick();
    idle_in();
    chk("dw_rsp", 64'(bus.o_d_rsp_valid), 1);
    chk("dw_code", 64'(bus.o_d_code),
        64'(MEM_CODE_WRITE));

    f_req(32'h10, MEM_COUNT_WORD);
    #1;
    chk("fr_gnt", 64'({bus.o_f_gnt, bus.o_d_gnt}), 2'b10);
    chk("fr_we", 64'(bus.o_mem_wr_en), 0);
    chk("fr_wd", 64'(bus.o_mem_wr_data), 0);
    tick();
    idle_in();
    chk("fr_rsp", 64'(bus.o_f_rsp_valid), 1);
    chk("fr_data", 64'(bus.o_f_rd_data), 32'hDEADBEEF);
    chk("fr_code", 64'(bus.o_f_code), 64'(MEM_CODE_READ));
    chk("fr_d_idle", 64'({bus.o_d_rsp_valid,
        bus.o_d_rd_data}), 0);
    chk("fr_d_code", 64'(bus.o_d_code),
        64'(MEM_CODE_INVALID));
    tick();

    f_req(32'h10, MEM_COUNT_WORD);
    d_req(32'h20, 32'h0, 1'b0, MEM_COUNT_WORD);
    for (int i = 0; i < 10; i++) begin
      exp_f = (i % 5 == 4);
      #1;
      chk($sformatf("st_gnt%0d", i),
          64'({bus.o_f_gnt, bus.o_d_gnt}),
          exp_f ? 64'd2 : 64'd1);
      tick();
      chk($sformatf("st_rsp%0d", i),
          64'({bus.o_f_rsp_valid, bus.o_d_rsp_valid}),
          exp_f ? 64'd2 : 64'd1);
      if (exp_f)
        chk($sformatf("st_fd%0d", i),
            64'(bus.o_f_rd_data), 32'hDEADBEEF);
    end
    idle_in();
    tick();

    f_req(32'h40, MEM_COUNT_NONE);
    #1;
    chk("fn_gnt", 64'(bus.o_f_gnt), 1);
    chk("fn_cnt", 64'(bus.o_mem_count),
        64'(MEM_COUNT_NONE));
    tick();
    idle_in();
    chk("fn_rsp", 64'(bus.o_f_rsp_valid), 1);
    chk("fn_code", 64'(bus.o_f_code),
        64'(MEM_CODE_INVALID));

    d_req(32'h3, 32'h1234, 1'b1, MEM_COUNT_HALF);
    #1;
    tick();
    idle_in();
    chk("mis_code", 64'(bus.o_d_code),
        64'(MEM_CODE_MISALIGNED));
    tick();
    chk("mis_err", 64'(err_sticky), 2'b10);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_err", 64'(err_sticky), 2'b00);

    d_req(32'(4 * WORD_COUNT), 32'h0, 1'b0,
          MEM_COUNT_WORD);
    #1;
    tick();
    idle_in();
    chk("oob_code", 64'(bus.o_d_code),
        64'(MEM_CODE_OUT_OF_BOUNDS));
    chk("oob_f_rsp", 64'(bus.o_f_rsp_valid), 0);
    chk("oob_f_code", 64'(bus.o_f_code),
        64'(MEM_CODE_INVALID));
    tick();
    chk("oob_err", 64'(err_sticky), 2'b10);

    d_req(32'h5, 32'h0, 1'b0, MEM_COUNT_WORD);
    #1;
    tick();
    idle_in();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("setwin_err", 64'(err_sticky), 2'b10);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    f_req(32'h2, MEM_COUNT_WORD);
    #1;
    tick();
    idle_in();
    chk("fmis_code", 64'(bus.o_f_code),
        64'(MEM_CODE_MISALIGNED));
    tick();
    chk("fmis_err", 64'(err_sticky), 2'b01);

    d_req(32'h10, 32'h0, 1'b0, MEM_COUNT_WORD);
    #1;
    chk("rm_gnt", 64'(bus.o_d_gnt), 1);
    tick();
    idle_in();
    aresetn = 1'b0;
    #1;
    chk("rm_rsp", 64'({bus.o_f_rsp_valid,
                       bus.o_d_rsp_valid}), 0);
    chk("rm_count", 64'(bus.o_mem_count),
        64'(MEM_COUNT_NONE));
    chk("rm_err", 64'(err_sticky), 0);
    tick();
    aresetn = 1'b1;
    tick();
    chk("rm_post", 64'(bus.o_d_rsp_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
